// File: rtl/qpsk_modulator_if.sv
// Bit-stream input handshake and DAC sample output of the QPSK modulator.
// The master side supplies bits and consumes samples; the slave side is the modulator.
interface qpsk_modulator_if;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic [7:0] wav_out;
    logic       wav_stb;

    modport master (
        output bit_in,
        output bit_valid,
        input  bit_ready,
        input  wav_out,
        input  wav_stb
    );

    modport slave (
        input  bit_in,
        input  bit_valid,
        output bit_ready,
        output wav_out,
        output wav_stb
    );
endinterface

// File: rtl/qpsk_modulator.sv
// QPSK baseband modulator: preamble of phase-0 sine symbols, one silent gap
// symbol, then a fixed number of payload symbols built from serial bit pairs.
// Each symbol is 32 samples of an offset sine; one sample per CLK_DIV clocks.
module qpsk_modulator #(
    parameter int CLK_DIV       = 4,
    parameter int PREAMBLE_SYMS = 8,
    parameter int PAYLOAD_SYMS  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    qpsk_modulator_if.slave     bus,
    output logic                busy,
    output logic                underrun
);

    localparam int DIV_W   = $clog2(CLK_DIV + 1);
    localparam int SYM_MAX = (PREAMBLE_SYMS > PAYLOAD_SYMS) ? PREAMBLE_SYMS : PAYLOAD_SYMS;
    localparam int SYM_W   = $clog2(SYM_MAX + 1);
    localparam int FET_W   = $clog2(PAYLOAD_SYMS + 1);
    localparam logic [7:0] MID_LEVEL = 8'h40;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_GAP,
        S_PAYLOAD
    } state_t;

    // One period of round(64 + 64*sin(2*pi*n/32)).
    function automatic logic [7:0] sine_lut(input logic [4:0] idx);
        logic [7:0] v;
        case (idx)
            5'd0:  v = 8'd64;   5'd1:  v = 8'd76;   5'd2:  v = 8'd88;   5'd3:  v = 8'd100;
            5'd4:  v = 8'd109;  5'd5:  v = 8'd117;  5'd6:  v = 8'd123;  5'd7:  v = 8'd127;
            5'd8:  v = 8'd128;  5'd9:  v = 8'd127;  5'd10: v = 8'd123;  5'd11: v = 8'd117;
            5'd12: v = 8'd109;  5'd13: v = 8'd100;  5'd14: v = 8'd88;   5'd15: v = 8'd76;
            5'd16: v = 8'd64;   5'd17: v = 8'd52;   5'd18: v = 8'd40;   5'd19: v = 8'd28;
            5'd20: v = 8'd19;   5'd21: v = 8'd11;   5'd22: v = 8'd5;    5'd23: v = 8'd1;
            5'd24: v = 8'd0;    5'd25: v = 8'd1;    5'd26: v = 8'd5;    5'd27: v = 8'd11;
            5'd28: v = 8'd19;   5'd29: v = 8'd28;   5'd30: v = 8'd40;   default: v = 8'd52;
        endcase
        return v;
    endfunction

    // Gray-style mapping so adjacent phases differ in one bit.
    function automatic logic [4:0] sym_phase(input logic [1:0] sym);
        logic [4:0] q;
        case (sym)
            2'b00:   q = 5'd0;
            2'b01:   q = 5'd8;
            2'b11:   q = 5'd16;
            default: q = 5'd24;
        endcase
        return q;
    endfunction

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [4:0]         n_q, n_d;
    logic [SYM_W-1:0]   sym_q, sym_d;
    logic [FET_W-1:0]   fetched_q, fetched_d;
    logic [4:0]         phase_q, phase_d;
    logic               silent_q, silent_d;
    logic [1:0]         bits_q, bits_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic               busy_q, busy_d;
    logic               underrun_q, underrun_d;
    logic [7:0]         wav_out_q, wav_out_d;
    logic               wav_stb_q, wav_stb_d;

    logic               tick;
    logic               ready;
    logic               accept;
    logic               take;
    logic [4:0]         lut_idx;

    assign tick    = (div_q == DIV_W'(CLK_DIV - 1));
    assign ready   = ((state_q == S_GAP) || (state_q == S_PAYLOAD)) &&
                     (cnt_q != 2'd2) && (fetched_q < FET_W'(PAYLOAD_SYMS));
    assign accept  = bus.bit_valid && ready;
    assign lut_idx = n_q + phase_q;

    assign bus.bit_ready = ready;
    assign bus.wav_out   = wav_out_q;
    assign bus.wav_stb   = wav_stb_q;
    assign busy          = busy_q;
    assign underrun      = underrun_q;

    // State register: everything returns to idle values on rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            n_q        <= '0;
            sym_q      <= '0;
            fetched_q  <= '0;
            phase_q    <= '0;
            silent_q   <= 1'b0;
            bits_q     <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            wav_out_q  <= MID_LEVEL;
            wav_stb_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            n_q        <= n_d;
            sym_q      <= sym_d;
            fetched_q  <= fetched_d;
            phase_q    <= phase_d;
            silent_q   <= silent_d;
            bits_q     <= bits_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
            wav_out_q  <= wav_out_d;
            wav_stb_q  <= wav_stb_d;
        end
    end

    // Next state: frame sequencing on sample ticks, start capture, bit buffer.
    always_comb begin
        div_d      = tick ? '0 : div_q + 1'b1;
        state_d    = state_q;
        n_d        = n_q;
        sym_d      = sym_q;
        fetched_d  = fetched_q;
        phase_d    = phase_q;
        silent_d   = silent_q;
        bits_d     = bits_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        busy_d     = busy_q;
        underrun_d = underrun_q;
        wav_out_d  = wav_out_q;
        wav_stb_d  = tick;
        take       = 1'b0;

        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (pend_q) begin
                        // The pending request turns this strobe into preamble sample 0.
                        wav_out_d = sine_lut(5'd0);
                        n_d       = 5'd1;
                        sym_d     = '0;
                        phase_d   = '0;
                        silent_d  = 1'b0;
                        pend_d    = 1'b0;
                        state_d   = S_PREAMBLE;
                    end else begin
                        wav_out_d = MID_LEVEL;
                        busy_d    = 1'b0;
                    end
                end
                S_PREAMBLE: begin
                    wav_out_d = sine_lut(n_q);
                    n_d       = n_q + 5'd1;
                    if (n_q == 5'd31) begin
                        if (sym_q == SYM_W'(PREAMBLE_SYMS - 1)) begin
                            sym_d   = '0;
                            state_d = S_GAP;
                        end else begin
                            sym_d = sym_q + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    wav_out_d = MID_LEVEL;
                    n_d       = n_q + 5'd1;
                    if (n_q == 5'd31) begin
                        sym_d   = '0;
                        state_d = S_PAYLOAD;
                    end
                end
                default: begin
                    if (n_q == 5'd0) begin
                        // Symbol boundary: only a complete pair already held counts.
                        if (cnt_q == 2'd2) begin
                            phase_d   = sym_phase(bits_q);
                            silent_d  = 1'b0;
                            wav_out_d = sine_lut(sym_phase(bits_q));
                            fetched_d = fetched_q + 1'b1;
                            take      = 1'b1;
                        end else begin
                            silent_d   = 1'b1;
                            underrun_d = 1'b1;
                            wav_out_d  = MID_LEVEL;
                        end
                    end else begin
                        wav_out_d = silent_q ? MID_LEVEL : sine_lut(lut_idx);
                    end
                    n_d = n_q + 5'd1;
                    if (n_q == 5'd31) begin
                        if (sym_q == SYM_W'(PAYLOAD_SYMS - 1)) begin
                            sym_d   = '0;
                            state_d = S_IDLE;
                        end else begin
                            sym_d = sym_q + 1'b1;
                        end
                    end
                end
            endcase
        end

        // A start is honoured only when fully idle and nothing is already pending.
        if (start && (state_q == S_IDLE) && !busy_q && !pend_q) begin
            pend_d     = 1'b1;
            busy_d     = 1'b1;
            underrun_d = 1'b0;
            fetched_d  = '0;
            bits_d     = '0;
            cnt_d      = '0;
        end

        // A pair consumed at a boundary leaves the buffer before any new bit lands.
        if (take) begin
            bits_d = '0;
            cnt_d  = '0;
        end
        if (accept) begin
            if (cnt_d == 2'd0) begin
                bits_d[1] = bus.bit_in;
                cnt_d     = 2'd1;
            end else begin
                bits_d[0] = bus.bit_in;
                cnt_d     = 2'd2;
            end
        end
    end

endmodule

// File: tb/tb_qpsk_modulator.sv
// Scoreboard bench for qpsk_modulator: each frame's expected sample stream is
// built from a floating-point sine reference and queued at start; a monitor
// pops one entry per wav_stb and compares sample and busy.
module tb_qpsk_modulator;

    localparam int CLK_DIV   = 4;
    localparam int PRE       = 2;
    localparam int PAY       = 8;
    localparam int BASE      = 32 * (PRE + 1);
    localparam int FRAME_LEN = 32 * (PRE + 1 + PAY);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic underrun;

    qpsk_modulator_if bus();

    qpsk_modulator #(
        .CLK_DIV       (CLK_DIV),
        .PREAMBLE_SYMS (PRE),
        .PAYLOAD_SYMS  (PAY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int exp_q[$];
    int frame_stb_cnt = 0;
    int table_t[32];
    logic [1:0] f_sym[PAY];
    bit         f_sil[PAY];

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int phase_of(input logic [1:0] s);
        case (s)
            2'b00:   return 0;
            2'b01:   return 8;
            2'b11:   return 16;
            default: return 24;
        endcase
    endfunction

    // Monitor: one queue entry per strobe while a frame is expected, else idle level.
    always @(negedge clk) begin
        if (rst == 1'b0 && bus.wav_stb === 1'b1) begin
            if (exp_q.size() > 0) begin
                int e;
                e = exp_q.pop_front();
                frame_stb_cnt++;
                check("frame_sample", 32'(bus.wav_out), e);
                check("busy_in_frame", 32'(busy), 1);
            end else begin
                check("idle_sample", 32'(bus.wav_out), 8'h40);
                check("busy_idle", 32'(busy), 0);
            end
        end
    end

    task automatic build_expected();
        for (int p = 0; p < PRE; p++)
            for (int n = 0; n < 32; n++) exp_q.push_back(table_t[n]);
        for (int n = 0; n < 32; n++) exp_q.push_back(64);
        for (int s = 0; s < PAY; s++)
            for (int n = 0; n < 32; n++)
                exp_q.push_back(f_sil[s] ? 64 : table_t[(n + phase_of(f_sym[s])) % 32]);
    endtask

    task automatic wait_strobe(input string name);
        int k;
        k = 0;
        while (bus.wav_stb !== 1'b1 && k < 4 * CLK_DIV) begin
            @(negedge clk);
            k++;
        end
        if (bus.wav_stb !== 1'b1) check(name, 32'(k), -1);
    endtask

    task automatic skip_silent(inout int j);
        while (j < PAY && f_sil[j]) j++;
    endtask

    // Runs one frame; optionally with random valid gaps, a start while busy,
    // or a reset once abort_at strobes of the frame have been seen.
    task automatic run_frame(input int abort_at, input bit gaps, input bit busy_start);
        int j, b, xfers, ndata, taken, held, ready_bad, cyc;
        bit any_sil, aborted;
        ndata = 0; any_sil = 0;
        for (int s = 0; s < PAY; s++) begin
            if (f_sil[s]) any_sil = 1; else ndata++;
        end
        @(negedge clk);
        wait_strobe("idle_strobe_timeout");
        #1 start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        frame_stb_cnt = 0;
        build_expected();
        check("busy_rise", 32'(busy), 1);
        check("underrun_after_start", 32'(underrun), 0);
        j = 0; b = 0; xfers = 0; ready_bad = 0; cyc = 0; aborted = 0;
        skip_silent(j);
        while (frame_stb_cnt < FRAME_LEN) begin
            if (cyc > FRAME_LEN * CLK_DIV + 100) begin
                check("frame_timeout", 32'(frame_stb_cnt), FRAME_LEN);
                break;
            end
            start = 1'b0;
            if (abort_at > 0 && frame_stb_cnt >= abort_at) begin
                rst = 1'b1;
                bus.bit_valid = 1'b0;
                @(negedge clk);
                check("rst_wav_out", 32'(bus.wav_out), 8'h40);
                check("rst_wav_stb", 32'(bus.wav_stb), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_bit_ready", 32'(bus.bit_ready), 0);
                check("rst_underrun", 32'(underrun), 0);
                #1 rst = 1'b0;
                exp_q.delete();
                aborted = 1;
                break;
            end
            taken = 0;
            for (int s = 0; s < PAY; s++)
                if (!f_sil[s] && frame_stb_cnt >= BASE + 32 * s + 1) taken++;
            held = xfers - 2 * taken;
            if (j < PAY && (j == 0 || frame_stb_cnt >= BASE + 32 * (j - 1) + 1)) begin
                bus.bit_valid = !(gaps && $urandom_range(3) == 0);
                bus.bit_in    = (b == 0) ? f_sym[j][1] : f_sym[j][0];
            end else if (!gaps) begin
                bus.bit_valid = 1'b1;
                bus.bit_in    = 1'($urandom_range(1));
            end else begin
                bus.bit_valid = 1'b0;
            end
            if (bus.bit_ready === 1'b1 &&
                (frame_stb_cnt < 32 * PRE || held >= 2 || taken >= PAY)) ready_bad++;
            if (bus.bit_valid && bus.bit_ready === 1'b1) begin
                xfers++;
                if (j < PAY) begin
                    b++;
                    if (b == 2) begin
                        b = 0;
                        j++;
                        skip_silent(j);
                    end
                end
            end
            if (busy_start && frame_stb_cnt == BASE + 100) start = 1'b1;
            @(negedge clk);
            #1 cyc++;
        end
        bus.bit_valid = 1'b0;
        start = 1'b0;
        if (!aborted) begin
            @(negedge clk);
            wait_strobe("end_strobe_timeout");
            check("transfers", 32'(xfers), 2 * ndata);
            check("underrun_end", 32'(underrun), any_sil ? 1 : 0);
            check("ready_violations", 32'(ready_bad), 0);
            check("idle_bit_ready", 32'(bus.bit_ready), 0);
            check("idle_busy", 32'(busy), 0);
        end
    endtask

    task automatic random_syms();
        for (int s = 0; s < PAY; s++) begin
            f_sym[s] = 2'($urandom_range(3));
            f_sil[s] = 1'b0;
        end
    endtask

    initial begin
        int k;
        for (int n = 0; n < 32; n++)
            table_t[n] = int'($floor(64.0 + 64.0 * $sin(2.0 * 3.14159265358979 * real'(n) / 32.0) + 0.5));
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_wav_out", 32'(bus.wav_out), 8'h40);
        check("reset_wav_stb", 32'(bus.wav_stb), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_bit_ready", 32'(bus.bit_ready), 0);
        check("reset_underrun", 32'(underrun), 0);
        rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (bus.wav_stb !== 1'b1 && k < 20);
            check("strobe_interval", 32'(k), CLK_DIV);
            check("idle_ready_low", 32'(bus.bit_ready), 0);
        end

        // Mapping: 00,01,11,10 lead the payload.
        random_syms();
        f_sym[0] = 2'b00; f_sym[1] = 2'b01; f_sym[2] = 2'b11; f_sym[3] = 2'b10;
        $display("frame 1: symbol mapping, random valid gaps");
        run_frame(0, 1'b1, 1'b0);

        // Underrun in payload slot 2.
        random_syms();
        f_sil[2] = 1'b1;
        $display("frame 2: underrun in slot 2");
        run_frame(0, 1'b1, 1'b0);

        // Continuous valid (backpressure) plus a start pulse while busy.
        random_syms();
        $display("frame 3: continuous valid, start while busy");
        run_frame(0, 1'b0, 1'b1);

        // Reset mid-payload after an underrun has been flagged.
        random_syms();
        f_sil[1] = 1'b1;
        $display("frame 4: reset during payload");
        run_frame(BASE + 32 * 3 + 5, 1'b1, 1'b0);

        // Full frames after the reset.
        random_syms();
        f_sil[$urandom_range(PAY - 1)] = 1'b1;
        $display("frame 5: random data, random underrun slot");
        run_frame(0, 1'b1, 1'b0);

        random_syms();
        $display("frame 6: random data, continuous valid");
        run_frame(0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
